clk_div_mc: RTL and testbench
=============================

Name: clk_div_mc

Overview:
- Multi-channel, parametrised integer clock divider.
- Each channel divides the single reference clock by its own programmable ratio.
- A new ratio takes effect only on a period boundary, so switching is glitch-free.
- A disabled channel finishes its current period and then parks low, so stops are glitch-free too.
- Each channel also emits a one-cycle tick at every period start, for use as a clock enable by logic that stays on i_ref_clk.
- Sits in the clock/reset subsystem and replaces the single-channel divider for the UART/peripheral clock domains.

Parameters:
- NUM_CH, 2, number of independent divider channels (>=1).
- DIV_RATIO_WIDTH, 8, width of each channel's ratio field; the counter width equals DIV_RATIO_WIDTH.
- RESET_RATIO, 2, effective ratio held in each channel's shadow register after reset.

Ports:
- i_ref_clk  in  1  reference clock. All logic is on its rising edge.
- i_rst  in  1  reset. Synchronous, active-high.
- i_clk_en  in  NUM_CH  per-channel run request.
- i_div_ratio  in  NUM_CH*DIV_RATIO_WIDTH  ratio of channel c at bits [c*W +: W].
- o_div_clk  out  NUM_CH  divided clocks.
- o_tick  out  NUM_CH  one-cycle pulse in the first cycle of each output period.
- o_active  out  NUM_CH  high while the channel is in RUN.

Behaviour:
- Reset (i_rst=1 at an edge), applied to every channel:
  - state=IDLE, cnt=0, r_act=RESET_RATIO.
  - o_div_clk=0, o_tick=0, o_active=0.
  - Reset mid-period aborts the period immediately; the output goes low at that edge.
- Effective ratio: eff(R) = 2 when R<2; otherwise R (see Optional Feature for the exception). High phase H=floor(r_act/2); low phase L=r_act-H.
  - Odd ratios give a longer low phase: R=3 -> 1 high/2 low; R=5 -> 2 high/3 low.
- Channel FSM, states IDLE and RUN. All outputs are registered.
  - IDLE, i_clk_en=0: hold; outputs 0.
  - IDLE, i_clk_en=1 at an edge: -> RUN; cnt<=0; r_act<=eff(i_div_ratio); o_div_clk<=1; o_tick<=1; o_active<=1.
    - Latency from en sampled high to the first rising o_div_clk is 1 cycle.
  - RUN, cnt != r_act-1: cnt<=cnt+1; o_div_clk<=(cnt+1 < H); o_tick<=0.
  - RUN, cnt == r_act-1 (boundary), i_clk_en=1: start a new period exactly as on the IDLE->RUN edge, resampling i_div_ratio.
  - RUN, boundary, i_clk_en=0: -> IDLE; o_div_clk<=0; o_tick<=0; o_active<=0.
- i_clk_en deasserted mid-period: ignored until the boundary. The period always completes.
- i_div_ratio changes mid-period: ignored. Only the value present at a boundary cycle (or the IDLE->RUN cycle) is loaded.
- Channels are fully independent. No phase alignment between channels is guaranteed.

Optional Feature:
- Macro CLK_DIV_MC_BYPASS_EN.
- Defined:
  - eff(R) = R for R in {0,1}; a ratio of 0 or 1 selects bypass.
  - In RUN with r_act<2: o_div_clk = i_ref_clk through a combinational mux; o_tick=1 every cycle; every cycle is a boundary.
  - Entry to and exit from bypass occur only at a boundary.
- Undefined:
  - Ratios 0 and 1 are treated as 2.
  - No combinational path from i_ref_clk to o_div_clk exists.

Decomposition:
- Package clk_div_mc_pkg:
  - state enum (IDLE, RUN);
  - MIN_RATIO=2 constant;
  - eff_ratio function.
- Sub-module clk_div_mc_ch: one channel (FSM, cnt, r_act, output registers).
- The top instantiates NUM_CH copies in a generate loop and slices the ratio bus.

Test Plan:
- Reset, then ch0 en=1 with R=4 -> o_tick pulses every 4 cycles; o_div_clk is high 2 / low 2; first high 1 cycle after en sampled.
- R=5 -> o_div_clk high 2, low 3, period 5; R=3 -> high 1, low 2.
- Running at R=4, write R=6 at cnt=1 -> the current period stays 4 cycles; the next period is 6 (3 high/3 low); no runt pulse.
- Deassert en at cnt=0 with R=8 -> the output completes 4 high + 4 low, then o_active=0 and the output stays 0; reassert en -> a new period starts next cycle.
- Assert i_rst mid-high-phase -> all outputs 0 at that edge; after release with en held, the output restarts with a full period.
- R=0 -> without the macro, period is 2 (1/1); with CLK_DIV_MC_BYPASS_EN, o_div_clk follows i_ref_clk and o_tick=1 every cycle, with the switch only at a boundary. Run ch0 R=2 and ch1 R=7 concurrently and confirm they are independent.

Source files
------------

// File: rtl/clk_div_mc_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Optional bypass of ratios 0/1 is enabled by defining CLK_DIV_MC_BYPASS_EN.
package clk_div_mc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned MIN_RATIO = 2;

    // Ratio actually loaded at a period start; ratios below 2 either bypass or clamp.
    function automatic logic [31:0] eff_ratio(input logic [31:0] r);
`ifdef CLK_DIV_MC_BYPASS_EN
        return r;
`else
        return (r < MIN_RATIO) ? 32'(MIN_RATIO) : r;
`endif
    endfunction

endpackage

// File: rtl/clk_div_mc_ch.sv
// One divider channel: IDLE/RUN FSM, period counter, shadow ratio, registered outputs.
// With CLK_DIV_MC_BYPASS_EN, ratios 0/1 route i_ref_clk straight to o_div_clk.
module clk_div_mc_ch #(
    parameter int unsigned DIV_RATIO_WIDTH = 8,
    parameter int unsigned RESET_RATIO     = 2
) (
    input  logic                       i_ref_clk,
    input  logic                       i_rst,
    input  logic                       i_clk_en,
    input  logic [DIV_RATIO_WIDTH-1:0] i_div_ratio,
    output logic                       o_div_clk,
    output logic                       o_tick,
    output logic                       o_active
);
    import clk_div_mc_pkg::*;

    localparam int unsigned W = DIV_RATIO_WIDTH;

    state_e         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   ract_q, ract_d;
    logic           div_q, div_d;
    logic           tick_q, tick_d;
    logic           act_q, act_d;

    logic [W-1:0]   cnt_inc;
    logic [W-1:0]   high_len;
    logic           boundary;
    logic           byp;

    assign cnt_inc  = cnt_q + W'(1);
    assign high_len = ract_q >> 1;

`ifdef CLK_DIV_MC_BYPASS_EN
    assign byp      = (ract_q < W'(MIN_RATIO));
`else
    assign byp      = 1'b0;
`endif
    // In bypass every cycle is a boundary, so the ratio can change on any edge.
    assign boundary = byp || (cnt_q == (ract_q - W'(1)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ract_d  = ract_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        act_d   = act_q;
        if ((state_q == IDLE) || boundary) begin
            if (i_clk_en) begin
                state_d = RUN;
                cnt_d   = '0;
                ract_d  = W'(eff_ratio(32'(i_div_ratio)));
                div_d   = 1'b1;
                tick_d  = 1'b1;
                act_d   = 1'b1;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
                div_d   = 1'b0;
                act_d   = 1'b0;
            end
        end else begin
            cnt_d = cnt_inc;
            div_d = (cnt_inc < high_len);
        end
    end

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ract_q  <= W'(RESET_RATIO);
            div_q   <= 1'b0;
            tick_q  <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ract_q  <= ract_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            act_q   <= act_d;
        end
    end

`ifdef CLK_DIV_MC_BYPASS_EN
    assign o_div_clk = (act_q && byp) ? i_ref_clk : div_q;
`else
    assign o_div_clk = div_q;
`endif
    assign o_tick   = tick_q;
    assign o_active = act_q;

endmodule

// File: rtl/clk_div_mc.sv
// Multi-channel integer clock divider: NUM_CH independent channels on one reference clock.
// Define CLK_DIV_MC_BYPASS_EN to let ratios 0/1 pass the reference clock through.
module clk_div_mc #(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned DIV_RATIO_WIDTH = 8,
    parameter int unsigned RESET_RATIO     = 2
) (
    input  logic                              i_ref_clk,
    input  logic                              i_rst,
    input  logic [NUM_CH-1:0]                 i_clk_en,
    input  logic [NUM_CH*DIV_RATIO_WIDTH-1:0] i_div_ratio,
    output logic [NUM_CH-1:0]                 o_div_clk,
    output logic [NUM_CH-1:0]                 o_tick,
    output logic [NUM_CH-1:0]                 o_active
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_div_mc_ch #(
            .DIV_RATIO_WIDTH (DIV_RATIO_WIDTH),
            .RESET_RATIO     (RESET_RATIO)
        ) u_ch (
            .i_ref_clk   (i_ref_clk),
            .i_rst       (i_rst),
            .i_clk_en    (i_clk_en[c]),
            .i_div_ratio (i_div_ratio[c*DIV_RATIO_WIDTH +: DIV_RATIO_WIDTH]),
            .o_div_clk   (o_div_clk[c]),
            .o_tick      (o_tick[c]),
            .o_active    (o_active[c])
        );
    end

endmodule

// File: tb/tb_clk_div_mc.sv
// Randomised scoreboard bench for clk_div_mc: a period-level model queues expected outputs.
module tb_clk_div_mc;

    localparam int NUM_CH = 2;
    localparam int W      = 8;

    logic                clk;
    logic                rst;
    logic [NUM_CH-1:0]   en;
    logic [NUM_CH*W-1:0] ratio;
    logic [NUM_CH-1:0]   div_clk, tick, active;

    typedef struct packed {
        logic d;
        logic t;
        logic a;
    } exp_t;

    exp_t expq [NUM_CH][$];
    int   checks = 0;
    int   errors = 0;
    bit   started = 0;

    clk_div_mc #(
        .NUM_CH          (NUM_CH),
        .DIV_RATIO_WIDTH (W),
        .RESET_RATIO     (2)
    ) dut (
        .i_ref_clk   (clk),
        .i_rst       (rst),
        .i_clk_en    (en),
        .i_div_ratio (ratio),
        .o_div_clk   (div_clk),
        .o_tick      (tick),
        .o_active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int eff(int r);
`ifdef CLK_DIV_MC_BYPASS_EN
        return r;
`else
        return (r < 2) ? 2 : r;
`endif
    endfunction

    // A whole output period: high for floor(r/2), low for the rest, tick on the first cycle.
    // In bypass the output follows the reference clock, which is low at the sampling edge.
    function automatic void push_period(int c, int r);
        if (r < 2) begin
            expq[c].push_back('{d: 1'b0, t: 1'b1, a: 1'b1});
        end else begin
            for (int i = 0; i < r; i++)
                expq[c].push_back('{d: (i < r / 2), t: (i == 0), a: 1'b1});
        end
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                expq[c].delete();
                expq[c].push_back('{d: 1'b0, t: 1'b0, a: 1'b0});
            end else if (expq[c].size() == 0) begin
                if (en[c]) push_period(c, eff(int'(ratio[c*W +: W])));
                else       expq[c].push_back('{d: 1'b0, t: 1'b0, a: 1'b0});
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int c = 0; c < NUM_CH; c++) begin
                exp_t e;
                checks++;
                if (expq[c].size() == 0) begin
                    errors++;
                    $display("FAIL ch%0d empty_queue at %0t: no expected value available", c, $time);
                end else begin
                    e = expq[c].pop_front();
                    if ({div_clk[c], tick[c], active[c]} !== {e.d, e.t, e.a}) begin
                        errors++;
                        $display("FAIL ch%0d outputs at %0t: got div/tick/act=%b%b%b expected %b%b%b",
                                 c, $time, div_clk[c], tick[c], active[c], e.d, e.t, e.a);
                    end
                end
            end
        end
    end

    task automatic set_ch(int c, bit e, int r);
        en[c]           = e;
        ratio[c*W +: W] = W'(r);
    endtask

    task automatic run(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        en    = '0;
        ratio = '0;
        run(3);
        rst = 1'b0;
        run(3);

        set_ch(0, 1, 4); set_ch(1, 1, 7);
        run(16);
        set_ch(1, 1, 2);
        set_ch(0, 1, 5);
        run(20);
        set_ch(0, 1, 3);
        run(15);

        set_ch(0, 1, 4);
        run(6);
        set_ch(0, 1, 6);
        run(16);

        set_ch(0, 1, 8);
        run(18);
        set_ch(0, 0, 8);
        run(14);
        set_ch(0, 1, 8);
        run(11);

        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(20);

        set_ch(0, 1, 0); set_ch(1, 1, 1);
        run(12);
        set_ch(0, 1, 5); set_ch(1, 1, 255);
        run(12);
        set_ch(1, 0, 255);
        run(520);

        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(7) == 0) ratio[c*W +: W] = W'($urandom_range(12));
                if ($urandom_range(15) == 0) en[c] = ~en[c];
            end
            rst = ($urandom_range(199) == 0);
            run(1);
        end
        rst = 1'b0;
        run(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
